// File: rtl/cam_pattern_generator_if.sv
// Pattern-generator control and byte-stream bundle.
// master = generator side, slave = consumer/controller side.
interface cam_pattern_generator_if #(
    parameter int DATA_W      = 8,
    parameter int FRAME_CNT_W = 16
);
    logic                   enable;
    logic                   continuous;
    logic [1:0]             mode;
    logic [DATA_W-1:0]      const_value;
    logic [DATA_W-1:0]      data_out;
    logic                   pixel_valid;
    logic                   href;
    logic                   vsync;
    logic                   line_start;
    logic                   frame_start;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic                   busy;

    modport master (
        input  enable, continuous, mode, const_value,
        output data_out, pixel_valid, href, vsync, line_start, frame_start,
               frame_done, frame_count, busy
    );

    modport slave (
        output enable, continuous, mode, const_value,
        input  data_out, pixel_valid, href, vsync, line_start, frame_start,
               frame_done, frame_count, busy
    );
endinterface

// File: rtl/cam_pattern_generator.sv
// OV7670-style camera timing and test-pattern source with registered outputs.
// Emits START/vsync, V_LINES x H_BYTES bytes with line pauses, then an END pause.
module cam_pattern_generator #(
    parameter int DATA_W      = 8,
    parameter int H_BYTES     = 1280,
    parameter int V_LINES     = 480,
    parameter int START_PAUSE = 17400,
    parameter int LINE_PAUSE  = 144,
    parameter int END_PAUSE   = 6255,
    parameter int VSYNC_LEN   = 1280,
    parameter int CHECK_SHIFT = 4,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    cam_pattern_generator_if.master bus
);
    localparam int H_W    = $clog2(H_BYTES);
    localparam int V_W    = $clog2(V_LINES + 1);
    localparam int P_MAX0 = (START_PAUSE > LINE_PAUSE) ? START_PAUSE : LINE_PAUSE;
    localparam int P_MAX  = (P_MAX0 > END_PAUSE) ? P_MAX0 : END_PAUSE;
    localparam int CNT_W  = $clog2(P_MAX + 1);
    // Lines narrower than 8 bytes get one-byte bars so the bar index stays defined.
    localparam int BW_EFF = (H_BYTES / 8 < 1) ? 1 : H_BYTES / 8;

    localparam logic [H_W-1:0]   H_LAST      = H_W'(H_BYTES - 1);
    localparam logic [H_W-1:0]   BW_LAST     = H_W'(BW_EFF - 1);
    localparam logic [V_W-1:0]   V_LAST      = V_W'(V_LINES - 1);
    localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_PAUSE - 1);
    localparam logic [CNT_W-1:0] PAUSE_LAST  = CNT_W'(LINE_PAUSE - 1);
    localparam logic [CNT_W-1:0] END_LAST    = CNT_W'(END_PAUSE - 1);
    localparam logic [CNT_W-1:0] VSYNC_M     = CNT_W'(VSYNC_LEN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_LINE, S_PAUSE, S_END} state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [H_W-1:0]         r_h;
    logic [H_W-1:0]         r_bar_cnt;
    logic [V_W-1:0]         r_v;
    logic [2:0]             r_bar;
    logic [1:0]             r_mode;
    logic [DATA_W-1:0]      r_const;
    logic                   r_cont;
    logic [DATA_W-1:0]      r_data_out;
    logic                   r_pixel_valid;
    logic                   r_href;
    logic                   r_vsync;
    logic                   r_line_start;
    logic                   r_frame_start;
    logic                   r_frame_done;
    logic [FRAME_CNT_W-1:0] r_frame_count;
    logic                   r_busy;

    logic                   w_end_last;
    logic                   w_start;
    logic [2:0]             w_nbar;
    logic [H_W-1:0]         w_nbar_cnt;
    logic [DATA_W-1:0]      w_cnt_next;

    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [1:0]        m,
        input logic [H_W-1:0]    h,
        input logic [V_W-1:0]    v,
        input logic [2:0]        bar,
        input logic [DATA_W-1:0] cnt,
        input logic [DATA_W-1:0] cv
    );
        logic [31:0] chk;
        chk = ((32'(h) >> CHECK_SHIFT) ^ (32'(v) >> CHECK_SHIFT)) & 32'd1;
        case (m)
            2'd0:    return cnt;
            2'd1:    return DATA_W'(bar) << (DATA_W - 3);
            2'd2:    return (chk != 32'd0) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            default: return cv;
        endcase
    endfunction

    always_comb begin
        w_end_last = (r_state == S_END) && (r_cnt == END_LAST);
        w_start    = ((r_state == S_IDLE) || (w_end_last && r_cont)) && bus.enable;
        w_nbar     = r_bar;
        w_nbar_cnt = r_bar_cnt + 1'b1;
        if (r_bar_cnt == BW_LAST && r_bar != 3'd7) begin
            w_nbar     = r_bar + 3'd1;
            w_nbar_cnt = '0;
        end
        w_cnt_next = r_data_out + 1'b1;
    end

    // Outputs are loaded together with the state they describe, so they need no decode delay.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_h           <= '0;
            r_bar_cnt     <= '0;
            r_v           <= '0;
            r_bar         <= '0;
            r_mode        <= '0;
            r_const       <= '0;
            r_cont        <= 1'b0;
            r_data_out    <= '0;
            r_pixel_valid <= 1'b0;
            r_href        <= 1'b0;
            r_vsync       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_START: begin
                    if (r_cnt == START_LAST) begin
                        r_state       <= S_LINE;
                        r_vsync       <= 1'b0;
                        r_h           <= '0;
                        r_v           <= '0;
                        r_bar         <= '0;
                        r_bar_cnt     <= '0;
                        r_pixel_valid <= 1'b1;
                        r_href        <= 1'b1;
                        r_line_start  <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_data_out    <= f_pattern(r_mode, '0, '0, 3'd0,
                                                   DATA_W'(r_frame_count), r_const);
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_vsync <= (r_cnt + 1'b1) < VSYNC_M;
                    end
                end
                S_LINE: begin
                    if (r_h == H_LAST) begin
                        r_pixel_valid <= 1'b0;
                        r_href        <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= (r_v == V_LAST) ? S_END : S_PAUSE;
                    end else begin
                        r_h        <= r_h + 1'b1;
                        r_bar      <= w_nbar;
                        r_bar_cnt  <= w_nbar_cnt;
                        r_data_out <= f_pattern(r_mode, r_h + 1'b1, r_v, w_nbar,
                                                w_cnt_next, r_const);
                    end
                end
                S_PAUSE: begin
                    if (r_cnt == PAUSE_LAST) begin
                        r_state       <= S_LINE;
                        r_v           <= r_v + 1'b1;
                        r_h           <= '0;
                        r_bar         <= '0;
                        r_bar_cnt     <= '0;
                        r_pixel_valid <= 1'b1;
                        r_href        <= 1'b1;
                        r_line_start  <= 1'b1;
                        r_data_out    <= f_pattern(r_mode, '0, r_v + 1'b1, 3'd0,
                                                   w_cnt_next, r_const);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (w_end_last) begin
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 1'b1;
                        r_state       <= S_IDLE;
                        r_busy        <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            // Frame settings are captured only here and stay frozen for the whole frame.
            if (w_start) begin
                r_state <= S_START;
                r_cnt   <= '0;
                r_vsync <= 1'b1;
                r_busy  <= 1'b1;
                r_mode  <= bus.mode;
                r_const <= bus.const_value;
                r_cont  <= bus.continuous;
            end
        end
    end

    assign bus.data_out    = r_data_out;
    assign bus.pixel_valid = r_pixel_valid;
    assign bus.href        = r_href;
    assign bus.vsync       = r_vsync;
    assign bus.line_start  = r_line_start;
    assign bus.frame_start = r_frame_start;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_count = r_frame_count;
    assign bus.busy        = r_busy;
endmodule

// File: tb/tb_cam_pattern_generator.sv
// Randomized bench for cam_pattern_generator against a frame-position reference model.
module tb_cam_pattern_generator;
    localparam int DW   = 8;
    localparam int H    = 16;
    localparam int V    = 3;
    localparam int SP   = 5;
    localparam int LP   = 2;
    localparam int EP   = 3;
    localparam int VL   = 2;
    localparam int CS   = 1;
    localparam int FCW  = 2;
    localparam int P    = H + LP;
    localparam int FLEN = SP + V * H + (V - 1) * LP + EP;
    localparam int BW   = H / 8;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;
    bit   chk_en = 0;

    cam_pattern_generator_if #(.DATA_W(DW), .FRAME_CNT_W(FCW)) bus ();

    cam_pattern_generator #(
        .DATA_W(DW), .H_BYTES(H), .V_LINES(V), .START_PAUSE(SP), .LINE_PAUSE(LP),
        .END_PAUSE(EP), .VSYNC_LEN(VL), .CHECK_SHIFT(CS), .FRAME_CNT_W(FCW)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: position t inside the frame, outputs derived arithmetically.
    bit        m_act = 0;
    bit        m_done = 0;
    int        m_t = 0;
    int        m_fc = 0;
    int        m_mode = 0;
    int        m_cv = 0;
    bit        m_cont = 0;
    int        m_data = 0;

    function automatic bit in_line(input int t);
        int u;
        if (t < SP) return 0;
        u = t - SP;
        if (u >= V * H + (V - 1) * LP) return 0;
        return (u % P) < H;
    endfunction

    function automatic int exp_byte(input int t);
        int u, h, v, bar;
        u = t - SP;
        h = u % P;
        v = u / P;
        bar = (h / BW > 7) ? 7 : h / BW;
        case (m_mode)
            0:       return (m_fc + v * H + h) % 256;
            1:       return bar * 32;
            2:       return ((((h >> CS) ^ (v >> CS)) & 1) != 0) ? 255 : 0;
            default: return m_cv;
        endcase
    endfunction

    task automatic m_begin();
        m_act  = 1;
        m_t    = 0;
        m_mode = int'(bus.mode);
        m_cv   = int'(bus.const_value);
        m_cont = bus.continuous;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_act = 0; m_t = 0; m_fc = 0; m_done = 0; m_data = 0;
        end else begin
            m_done = 0;
            if (m_act) begin
                if (m_t == FLEN - 1) begin
                    m_done = 1;
                    m_fc   = (m_fc + 1) % (1 << FCW);
                    m_act  = 0;
                    if (m_cont && bus.enable) m_begin();
                end else begin
                    m_t++;
                end
            end else if (bus.enable) begin
                m_begin();
            end
            if (m_act && in_line(m_t)) m_data = exp_byte(m_t);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit pv, ls, fs, vs;
            int u;
            u  = m_t - SP;
            pv = m_act && in_line(m_t);
            vs = m_act && (m_t < VL);
            ls = pv && ((u % P) == 0);
            fs = ls && ((u / P) == 0);
            chk("ctl", 32'({bus.busy, bus.vsync, bus.pixel_valid, bus.href,
                            bus.line_start, bus.frame_start, bus.frame_done}),
                32'({m_act, vs, pv, pv, ls, fs, m_done}));
            chk("data", 32'(bus.data_out), 32'(m_data));
            chk("fcnt", 32'(bus.frame_count), 32'(m_fc));
            if (bus.frame_done) n_done++;
        end
    end

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (bus.busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic single(input int m, input int cv);
        int n = 0;
        bus.mode        = 2'(m);
        bus.const_value = DW'(cv);
        bus.continuous  = 1'b0;
        bus.enable      = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        while (bus.busy && n < 4 * FLEN) begin
            n++;
            @(negedge clk);
        end
        chk("busy_len", 32'(n), 32'(FLEN));
        chk("done_pulse", 32'(bus.frame_done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        reset           = 1'b1;
        bus.enable      = 1'b0;
        bus.continuous  = 1'b0;
        bus.mode        = 2'd0;
        bus.const_value = '0;
        @(negedge clk);
        chk_en = 1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_fcnt", 32'(bus.frame_count), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        single(0, 0);
        chk("fcnt_after_one", 32'(bus.frame_count), 32'd1);
        single(1, 0);
        single(2, 0);
        single(3, 8'hA5);

        // Settings change mid-frame must not leak into the running frame.
        bus.mode = 2'd3; bus.const_value = 8'h5A; bus.continuous = 1'b0; bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (20) @(negedge clk);
        bus.mode = 2'd0; bus.const_value = 8'h11;
        wait_idle(4 * FLEN);
        @(negedge clk);
        single(0, 8'h11);

        // Back-to-back frames, enable dropped during the third.
        bus.mode = 2'd0; bus.continuous = 1'b1; bus.enable = 1'b1;
        d0 = n_done;
        repeat (2 * FLEN + 10) @(negedge clk);
        bus.enable = 1'b0;
        wait_idle(4 * FLEN);
        @(negedge clk);
        chk("cont_done_cnt", 32'(n_done - d0), 32'd3);

        // Reset in the middle of line 1, byte 2.
        bus.mode = 2'd2; bus.continuous = 1'b0; bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
        repeat (SP + H + LP + 2) @(negedge clk);
        chk("mid_pv", 32'(bus.pixel_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_fcnt", 32'(bus.frame_count), 32'd0);
        chk("rst_mid_done", 32'(bus.frame_done), 32'd0);
        single(2, 0);

        // Frame counter wrap with a 2-bit counter.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            single(0, 0);
            chk("wrap", 32'(bus.frame_count), 32'((i + 1) % 4));
        end

        for (int it = 0; it < 25; it++) begin
            bus.mode        = 2'($urandom_range(0, 3));
            bus.const_value = DW'($urandom);
            bus.continuous  = ($urandom_range(0, 2) != 0);
            bus.enable      = ($urandom_range(0, 3) != 0);
            reset           = ($urandom_range(0, 11) == 0);
            @(negedge clk);
            reset = 1'b0;
            repeat ($urandom_range(1, 90)) @(negedge clk);
        end
        bus.enable = 1'b0;
        wait_idle(4 * FLEN);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cam_pattern_generator.md
Name:
cam_pattern_generator

Overview:
Parametrised, registered-output camera timing and test-pattern source. It emulates an OV7670-style byte stream: a start pause with vsync, V_LINES lines of H_BYTES bytes qualified by href/pixel_valid, a pause between lines, and an end pause. It has selectable pattern modes, single-shot or continuous framing, and a frame counter. It drives the capture/Ethernet path in place of the real sensor for bring-up and regression.

Parameters:
DATA_W, 8, byte width of data_out
H_BYTES, 1280, bytes per line (2 bytes per pixel at 640 wide); must be >=2
V_LINES, 480, lines per frame; must be >=1
START_PAUSE, 17400, cycles in START state; must be >=1
LINE_PAUSE, 144, cycles between lines; must be >=1
END_PAUSE, 6255, cycles in END state; must be >=1
VSYNC_LEN, 1280, vsync high cycles at start of START; must satisfy 1<=VSYNC_LEN<=START_PAUSE
CHECK_SHIFT, 4, checker square size is 2^CHECK_SHIFT bytes/lines
FRAME_CNT_W, 16, width of frame_count

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable  in  1  level; starts a frame from IDLE and permits continuation
continuous  in  1  1 = back-to-back frames while enable is high; 0 = single frame
mode  in  2  0 = byte counter, 1 = colour bars, 2 = checker, 3 = constant
const_value  in  DATA_W  byte used in mode 3
data_out  out  DATA_W  pattern byte, valid when pixel_valid=1
pixel_valid  out  1  registered byte qualifier (no clock gating)
href  out  1  high for every byte of a line (equal to pixel_valid)
vsync  out  1  frame sync at the start of START
line_start  out  1  high with the first byte of each line
frame_start  out  1  high with the first byte of line 0
frame_done  out  1  one-cycle pulse at the end of a frame
frame_count  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all outputs 0; frame_count 0; internal counters 0. Reset mid-frame aborts immediately with no frame_done pulse.
- All outputs are registered. State-derived outputs reflect the current state with no extra delay.
- IDLE: if enable=1, go to START on the next cycle. On that transition, latch mode, const_value and continuous. These stay frozen for the whole frame.
- START: lasts exactly START_PAUSE cycles. vsync=1 during its first VSYNC_LEN cycles, then 0. Then go to LINE with line index v=0.
- LINE: lasts exactly H_BYTES cycles with pixel_valid=href=1. Horizontal index h runs 0..H_BYTES-1. line_start=1 at h=0. frame_start=1 at h=0 and v=0. After h=H_BYTES-1: if v=V_LINES-1, go to END; otherwise go to LINE_PAUSE.
- LINE_PAUSE: lasts exactly LINE_PAUSE cycles with href=0. Then v increments and the state returns to LINE.
- END: lasts exactly END_PAUSE cycles. On the cycle after the last END cycle:
  - frame_done=1 for that one cycle;
  - frame_count increments;
  - if latched continuous=1 and enable=1, the state is START (new settings latched); otherwise it is IDLE.
- Frame length in cycles: START_PAUSE + V_LINES*H_BYTES + (V_LINES-1)*LINE_PAUSE + END_PAUSE.
- Deasserting enable mid-frame does not truncate the frame. It only prevents the next frame.
- Patterns (value on the byte at indices h, v):
  - mode 0: running byte counter. Starts at frame_count[DATA_W-1:0] on the first byte of the frame and increments by 1 per valid byte, wrapping modulo 2^DATA_W. It does not reset per line.
  - mode 1: 8 vertical bars. Bar width BW = H_BYTES/8 (integer, elaboration time). bar = min(h/BW, 7), tracked with a counter, no divider. data = bar placed in the top 3 bits, lower bits 0.
  - mode 2: data is all ones if h[CHECK_SHIFT] XOR v[CHECK_SHIFT], else 0.
  - mode 3: data = latched const_value.
- data_out holds its last value while pixel_valid=0.
- h and v counters are wide enough for H_BYTES and V_LINES. They never wrap inside a frame.

Test Plan:
- Timing, single shot. Small parameters: H_BYTES=4, V_LINES=3, START_PAUSE=5, LINE_PAUSE=2, END_PAUSE=3, VSYNC_LEN=2. mode 0, continuous=0, one-cycle enable pulse -> busy for exactly 24 cycles. vsync high for 2 cycles. Three bursts of 4 pixel_valid cycles separated by 2 idle cycles. data_out 0..11. frame_done one pulse. frame_count=1. Returns to IDLE.
- Continuous: same parameters, enable held high for 3 frames -> frames back-to-back with no IDLE gap. Three frame_done pulses 24 cycles apart. Counter-mode first bytes 0, 1, 2. Frame after enable drops completes fully, then IDLE.
- Patterns: H_BYTES=16, mode 1 -> bytes 0x00,0x00,0x20,0x20,...,0xE0,0xE0. CHECK_SHIFT=1, mode 2 -> line 0 = 00,00,FF,FF repeating; line 2 inverted.
- Mode latch: switch mode from 3 to 0 and const_value 0x5A to 0x11 mid-frame -> whole frame stays 0x5A. Next frame uses mode 0.
- Reset mid-line: assert reset at v=1, h=2 -> next cycle all outputs 0, frame_count 0, no frame_done. Re-enable -> a clean full frame.
- Wrap: FRAME_CNT_W=2, run 5 frames -> frame_count 1, 2, 3, 0, 1.
